program_loader: RTL
===================

# program_loader

Boot-time program loader for the single-cycle RISC-V core. It receives a length-prefixed, checksummed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. It writes each word into program memory through the memory's write port, holding the core in reset until a load completes without error. It sits between the host-side byte source (UART receiver or testbench) and the program memory / core reset input.

## Interface

Parameters:

- PROGRAM_MEMORY_DEPTH, 64: capacity of program memory in 32-bit words; the maximum accepted word count.
- BASE_ADDRESS, 32'h0000_0000: byte address of word 0.

Ports:

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start_i  in  1  level-sampled request to begin a load.
- Byte_Valid_i  in  1  the source presents a byte.
- Byte_Data_i  in  8  stream byte.
- Byte_Ready_o  out  1  loader accepts a byte. A transfer occurs on a cycle with Byte_Valid_i=1 and Byte_Ready_o=1.
- Mem_Write_o  out  1  one-cycle program-memory write strobe.
- Mem_Address_o  out  32  word-aligned byte address for the write.
- Mem_Write_Data_o  out  32  instruction word to write.
- Core_Reset_n_o  out  1  active-low reset to the core; 1 only in DONE.
- Done_o  out  1  load completed with a good checksum.
- Error_o  out  1  load aborted: length overflow or checksum mismatch.

## Operation

Stream format:

- Byte 0: N[7:0].
- Byte 1: N[15:8].
- Then N×4 payload bytes, least-significant byte of each word first.
- Then 1 checksum byte, equal to the 8-bit modulo-256 sum of the payload bytes only.

FSM states are IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR. Reset enters IDLE.

- IDLE: Start_i=1 -> LEN_LO. Clear the word index, byte lane, and checksum accumulator.
- LEN_LO: a transfer latches N[7:0] -> LEN_HI.
- LEN_HI: a transfer latches N[15:8]. The next state depends on the full 16-bit N:
  - N > PROGRAM_MEMORY_DEPTH -> ERROR.
  - N = 0 -> CHECK.
  - otherwise -> DATA.
- DATA: each transfer shifts the byte into lane 0..3 and adds it to the 8-bit accumulator, which wraps modulo 256.
  - When lane 3 is accepted, the assembled word is registered for writing and the word index increments.
  - When lane 3 of word N-1 is accepted -> CHECK.
- CHECK: a transfer compares the received byte with the accumulator.
  - Equal -> DONE.
  - Not equal -> ERROR.
- DONE / ERROR: terminal states. Start_i=1 -> LEN_LO, with all counters and the accumulator cleared.
- Start_i is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- Memory contents written before an error are not rolled back; the core remains in reset.

Output decode:

- Byte_Ready_o = 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 otherwise.
- Core_Reset_n_o = 1 in DONE only.
- Done_o = 1 in DONE only.
- Error_o = 1 in ERROR only.
- Mem_Address_o = BASE_ADDRESS + 4 × word_index of the word being written. Arithmetic is 32-bit unsigned; the index is at most PROGRAM_MEMORY_DEPTH-1, so no wrap occurs.
- Mem_Write_Data_o = {lane3, lane2, lane1, lane0}.

## Timing

Reset values, with reset asserted asynchronously:

- State IDLE.
- Byte_Ready_o=0, Mem_Write_o=0, Mem_Address_o=BASE_ADDRESS, Mem_Write_Data_o=0.
- Core_Reset_n_o=0, Done_o=0, Error_o=0.
- Reset asserted mid-load aborts immediately to these values. Reset deassertion is consumed synchronously.

Cycle behaviour:

- Start_i sampled high in IDLE/DONE/ERROR at edge k: Byte_Ready_o=1 from cycle k+1.
- Mem_Write_o pulses for exactly one cycle, in the cycle after the lane-3 transfer, with address and data stable in that cycle.
- Byte_Ready_o stays 1 during the write cycle. A full-rate stream of one byte per cycle is sustained with no stalls, since writes are at least 4 cycles apart.
- Final word: its write cycle coincides with the first CHECK cycle.
- Done_o/Error_o/Core_Reset_n_o change in the cycle after the deciding transfer: the LEN_HI transfer on overflow, or the checksum transfer.
- No transfer occurs while Byte_Valid_i=0; the FSM holds state.

## Test plan

- Load N=2, bytes 02 00 93 00 50 00 33 81 10 00 A7 at 1 byte/cycle:
  - writes 0x00500093 @0x0 and 0x00108133 @0x4, one Mem_Write_o pulse each;
  - Done_o=1 and Core_Reset_n_o=1 one cycle after the A7 transfer.
- Same stream with checksum byte A6 -> both writes still occur; Error_o=1, Done_o=0, Core_Reset_n_o stays 0.
- N=65 (41 00) with default depth -> Error_o=1 the cycle after byte 1, Byte_Ready_o=0, no Mem_Write_o ever.
- N=0 followed by checksum 00 -> Done_o=1 with no writes.
- N=0 followed by checksum 01 -> Error_o=1 with no writes.
- Run the N=2 stream with Byte_Valid_i toggling randomly, then assert reset low in the middle of word 1 -> all outputs return to their reset values at once. Then Start_i plus the full stream -> same two writes and Done_o=1.
- From DONE, pulse Start_i and send N=1, word 0x00000013, checksum 13 -> one write of 0x00000013 @0x0. Core_Reset_n_o=0 throughout the load and 1 again at DONE.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: parses a length-prefixed, checksummed byte stream,
// writes little-endian 32-bit words to program memory and releases the core on success.
module program_loader #(
    parameter int unsigned PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS         = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_i,
    input  logic        Byte_Valid_i,
    input  logic [7:0]  Byte_Data_i,
    output logic        Byte_Ready_o,
    output logic        Mem_Write_o,
    output logic [31:0] Mem_Address_o,
    output logic [31:0] Mem_Write_Data_o,
    output logic        Core_Reset_n_o,
    output logic        Done_o,
    output logic        Error_o
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [23:0]         lanes_q, lanes_d;
    logic                wr_d;
    logic [WORD_W-1:0]   addr_d, wdata_d;
    logic                ready_d, done_d, err_d;
    logic                xfer;
    logic [LEN_W-1:0]    len_full;

    assign xfer     = Byte_Valid_i && Byte_Ready_o;
    assign len_full = {Byte_Data_i, len_q[7:0]};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        csum_d  = csum_q;
        lanes_d = lanes_q;
        wr_d    = 1'b0;
        addr_d  = Mem_Address_o;
        wdata_d = Mem_Write_Data_o;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (Start_i) begin
                    state_d = LEN_LO;
                    idx_d   = '0;
                    lane_d  = '0;
                    csum_d  = '0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d   = {8'h00, Byte_Data_i};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (32'(len_full) > PROGRAM_MEMORY_DEPTH) begin
                        state_d = ERROR;
                    end else if (len_full == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    csum_d = csum_q + Byte_Data_i;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: lanes_d[7:0]   = Byte_Data_i;
                        2'd1: lanes_d[15:8]  = Byte_Data_i;
                        2'd2: lanes_d[23:16] = Byte_Data_i;
                        default: begin
                            // Lane 3 completes the word; write it out next cycle
                            wr_d    = 1'b1;
                            addr_d  = BASE_ADDRESS + {14'd0, idx_q, 2'b00};
                            wdata_d = {Byte_Data_i, lanes_q};
                            idx_d   = idx_q + 16'd1;
                            if ((idx_q + 16'd1) == len_q) begin
                                state_d = CHECK;
                            end
                        end
                    endcase
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_d = (Byte_Data_i == csum_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                  (state_d == DATA)   || (state_d == CHECK);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERROR);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            len_q            <= '0;
            idx_q            <= '0;
            lane_q           <= '0;
            csum_q           <= '0;
            lanes_q          <= '0;
            Byte_Ready_o     <= 1'b0;
            Mem_Write_o      <= 1'b0;
            Mem_Address_o    <= BASE_ADDRESS;
            Mem_Write_Data_o <= '0;
            Core_Reset_n_o   <= 1'b0;
            Done_o           <= 1'b0;
            Error_o          <= 1'b0;
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            idx_q            <= idx_d;
            lane_q           <= lane_d;
            csum_q           <= csum_d;
            lanes_q          <= lanes_d;
            Byte_Ready_o     <= ready_d;
            Mem_Write_o      <= wr_d;
            Mem_Address_o    <= addr_d;
            Mem_Write_Data_o <= wdata_d;
            Core_Reset_n_o   <= done_d;
            Done_o           <= done_d;
            Error_o          <= err_d;
        end
    end

endmodule
